// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_bank button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 1000000;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_HOLD_CYCLES   = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10000000;

    // Bits needed to hold counts 0 .. n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, stability FSM with counter, and the
// hold-to-repeat generator when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_repeat
);

    localparam int unsigned    CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    db_state_t              r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   r_level, w_level_nxt;
    logic                   r_rise, w_rise_nxt;
    logic                   r_fall, w_fall_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Counter is cleared on every state exit, so it never needs to wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            IDLE_LOW: begin
                if (w_sync) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            IDLE_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (w_sync) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int unsigned RW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rcnt;
    logic          r_first;
    logic          r_repeat;

    // Release takes priority over a repeat that would land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcnt   <= '0;
            r_first  <= 1'b1;
            r_repeat <= 1'b0;
        end else if (w_rise_nxt || w_fall_nxt || !r_level) begin
            r_rcnt   <= '0;
            r_first  <= 1'b1;
            r_repeat <= 1'b0;
        end else if (r_rcnt == (r_first ? HOLD_LAST : REP_LAST)) begin
            r_rcnt   <= '0;
            r_first  <= 1'b0;
            r_repeat <= 1'b1;
        end else begin
            r_rcnt   <= r_rcnt + RW'(1);
            r_repeat <= 1'b0;
        end
    end

    assign btn_repeat = r_repeat;
`else
    // Repeat timing is accepted for drop-in compatibility but has no effect here.
    localparam bit REPEAT_TIMING_SET = (HOLD_CYCLES != 0) || (REPEAT_CYCLES != 0);
    assign btn_repeat = 1'b0 & REPEAT_TIMING_SET;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent button debouncers with level, rise, fall and repeat outputs.
// Define DEBOUNCE_BANK_REPEAT_EN to build the hold-to-repeat pulse generators.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_repeat
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .btn_in     (btn_in[i]),
            .btn_level  (btn_level[i]),
            .btn_rise   (btn_rise[i]),
            .btn_fall   (btn_fall[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with a pulse scoreboard; honours DEBOUNCE_BANK_REPEAT_EN.
module tb_debounce_bank;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_REP  = 2;
    localparam int LAT    = 6;  // SYNC_STAGES + STABLE_CYCLES
    localparam int HOLD   = 8;
    localparam int REP    = 3;

    typedef struct {
        int edge_n;
        int ch;
        int kind;
    } evt_t;

    logic       clk;
    logic       reset;
    logic [1:0] btn_in;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [1:0] btn_repeat;

    int   edge_no = 0;
    int   checks  = 0;
    int   errors  = 0;
    evt_t sb[$];

    debounce_bank #(
        .N_CH          (2),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_fall   (btn_fall),
        .btn_repeat (btn_repeat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic string kname(input int k);
        if (k == K_RISE) return "rise";
        if (k == K_FALL) return "fall";
        return "repeat";
    endfunction

    // Every cycle, each pulse output must be high exactly when an event is due.
    always @(negedge clk) begin : monitor
        logic obs;
        logic exp;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 3; k++) begin
                obs = (k == K_RISE) ? btn_rise[ch] : (k == K_FALL) ? btn_fall[ch] : btn_repeat[ch];
                exp = 1'b0;
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].edge_n == edge_no && sb[i].ch == ch && sb[i].kind == k) begin
                        exp = 1'b1;
                        sb.delete(i);
                    end
                end
                checks++;
                assert (obs === exp) else begin
                    errors++;
                    $error("FAIL %s ch%0d edge %0d: observed=%b expected=%b", kname(k), ch, edge_no, obs, exp);
                end
            end
        end
    end

    task automatic purge(input int ch, input int after);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].ch == ch && sb[i].edge_n > after) sb.delete(i);
    endtask

    task automatic push_rise(input int ch);
        int r;
        r = edge_no + LAT;
        sb.push_back('{r, ch, K_RISE});
`ifdef DEBOUNCE_BANK_REPEAT_EN
        for (int k = 0; k < 20; k++) sb.push_back('{r + HOLD + REP * k, ch, K_REP});
`endif
    endtask

    task automatic push_fall(input int ch);
        int f;
        f = edge_no + LAT;
        purge(ch, f - 1);
        sb.push_back('{f, ch, K_FALL});
    endtask

    task automatic chk_level(input logic [1:0] exp, input string tag);
        checks++;
        assert (btn_level === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, btn_level, exp);
        end
    endtask

    task automatic chk_pulses(input string tag);
        checks++;
        assert ({btn_rise, btn_fall, btn_repeat} === 6'b0) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=000000", tag, {btn_rise, btn_fall, btn_repeat});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        btn_in = 2'b00;
        #2 reset = 1'b1;
        #1 chk_level(2'b00, "reset_level");
        chk_pulses("reset_pulses");
        cyc(3);
        reset = 1'b0;
        cyc(4);

        // Clean press on channel 0, held for 20 cycles, then released.
        btn_in = 2'b01;
        push_rise(0);
        cyc(5); chk_level(2'b00, "press_early");
        cyc(1); chk_level(2'b01, "press_accept");
        cyc(14);
        btn_in = 2'b00;
        push_fall(0);
        cyc(5); chk_level(2'b01, "release_early");
        cyc(1); chk_level(2'b00, "release_accept");
        cyc(4);

        // Bounce 1,0,1,0 at one-cycle spacing, then hold high.
        btn_in = 2'b01; cyc(1);
        btn_in = 2'b00; cyc(1);
        btn_in = 2'b01; cyc(1);
        btn_in = 2'b00; cyc(1);
        btn_in = 2'b01;
        push_rise(0);
        cyc(5); chk_level(2'b00, "bounce_early");
        cyc(1); chk_level(2'b01, "bounce_accept");

        // Three-cycle glitch on channel 1 must be rejected.
        btn_in = 2'b11; cyc(3);
        btn_in = 2'b01; cyc(8);
        chk_level(2'b01, "glitch_ignored");
        btn_in = 2'b00;
        push_fall(0);
        cyc(5); chk_level(2'b01, "release2_early");
        cyc(1); chk_level(2'b00, "release2_accept");
        cyc(4);

        // Reset with ch0 high and ch1 mid-wait; both held through release.
        btn_in = 2'b01;
        push_rise(0);
        cyc(8); chk_level(2'b01, "pre_reset");
        btn_in = 2'b11;
        push_rise(1);
        cyc(3);
        #2 reset = 1'b1;
        purge(0, edge_no);
        purge(1, edge_no);
        #1 chk_level(2'b00, "reset_async_level");
        chk_pulses("reset_async_pulses");
        cyc(2);
        reset = 1'b0;
        push_rise(0);
        push_rise(1);
        cyc(5); chk_level(2'b00, "post_reset_early");
        cyc(1); chk_level(2'b11, "post_reset_accept");
        cyc(16);
        btn_in = 2'b00;
        push_fall(0);
        push_fall(1);
        cyc(5); chk_level(2'b11, "final_release_early");
        cyc(1); chk_level(2'b00, "final_release_accept");
        cyc(10);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button debouncer for the board's button inputs. Each channel synchronises its raw input and requires the input to hold a new value for a programmable number of consecutive clock cycles before changing its level. It then emits one-cycle press and release pulses to downstream logic such as the 7-segment display controller. An optional hold-to-repeat pulse generator can be compiled in.

## Interface
- N_CH, default 5: number of independent button channels.
- STABLE_CYCLES, default 1000000: consecutive stable cycles needed to accept a change (10 ms at 100 MHz); must be ≥ 2.
- SYNC_STAGES, default 2: flip-flops in each input synchroniser; must be ≥ 2.
- HOLD_CYCLES, default 50000000: cycles the level must stay high before the first repeat pulse (repeat build only).
- REPEAT_CYCLES, default 10000000: spacing between repeat pulses (repeat build only).
- clk  input  1  system clock; every register is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  N_CH  raw, asynchronous, bouncing button inputs.
- btn_level  output  N_CH  debounced level, registered.
- btn_rise  output  N_CH  one-cycle pulse when btn_level goes 0→1.
- btn_fall  output  N_CH  one-cycle pulse when btn_level goes 1→0.
- btn_repeat  output  N_CH  one-cycle auto-repeat pulses while held; constant 0 when the feature is compiled out.

## Operation
- Channels are fully independent; nothing is shared between them except clk and reset.
- The synchroniser chain feeds a per-channel FSM with four states:
  - IDLE_LOW: level 0. sync=1 → WAIT_HIGH, counter cleared to 0.
  - WAIT_HIGH: level 0. sync=1 → counter increments. sync=0 → IDLE_LOW and counter cleared; no pulse.
  - IDLE_HIGH: level 1. sync=0 → WAIT_LOW, counter cleared to 0.
  - WAIT_LOW: level 1. Mirror image of WAIT_HIGH.
- Acceptance: in a WAIT state, when counter = STABLE_CYCLES−2 and sync still differs from the level, the next edge does all of the following: enters the opposite IDLE state, toggles btn_level, asserts the matching rise/fall pulse for exactly one cycle, and clears the counter.
- Counter width is $clog2(STABLE_CYCLES). The counter never wraps, because it is cleared on every state exit.
- Any bounce, however short, restarts the stability window.
- btn_rise and btn_fall for the same channel are never high in the same cycle.
- Reset values: btn_level, btn_rise, btn_fall and btn_repeat = 0; synchroniser flops = 0; FSM in IDLE_LOW; all counters = 0.
- Reset asserted mid-WAIT aborts the pending transition with no pulse.
- A button held through reset release is treated as a fresh press and produces btn_rise after the full latency.

## Timing
- Latency from a btn_in change (set up before edge 0) to btn_level and the pulse: SYNC_STAGES + STABLE_CYCLES rising edges.
- Pulses last exactly one clk cycle and are aligned with the btn_level update.
- Minimum spacing between successive rise/fall events on one channel: STABLE_CYCLES cycles.
- Reset takes effect on outputs immediately, with no clock required. Release must be synchronous to clk; the reset source is responsible for that.

## Configuration
- Macro: DEBOUNCE_BANK_REPEAT_EN.
- Defined: each channel has a repeat counter that starts when the level goes high.
  - First btn_repeat pulse occurs HOLD_CYCLES cycles after btn_rise.
  - Further pulses follow every REPEAT_CYCLES cycles while the level stays 1.
  - btn_fall or reset clears the counter immediately; no repeat pulse in that cycle.
- Undefined: no repeat logic is generated; btn_repeat is tied to 0; HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Structure
- Package debounce_pkg holds:
  - the 2-bit state typedef (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW);
  - a counter-width helper function;
  - default constants for STABLE_CYCLES and SYNC_STAGES.
- Sub-module debounce_channel contains one synchroniser, the FSM, the counter and the optional repeat logic.
- debounce_bank instantiates N_CH copies of debounce_channel in a generate loop.

## Test plan
All scenarios use N_CH=2, STABLE_CYCLES=4, SYNC_STAGES=2, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- Clean press: btn_in[0] goes 0→1 before edge 0 and is held for 20 cycles → btn_level[0]=1 and btn_rise[0] high only after edge 6; channel 1 stays 0.
- Bounce: btn_in[0] toggles 1,0,1,0 at 1-cycle spacing, then holds 1 → no pulse during bouncing; a single btn_rise[0] 6 edges after the final 0→1.
- Glitch: btn_in[1] high for 3 cycles, then low → btn_level[1] and all pulses stay 0.
- Release: from level 1, btn_in[0] goes 1→0 → btn_fall[0] single pulse and btn_level[0]=0 after 6 edges; btn_rise[0] stays 0.
- Reset mid-wait: reset asserted 3 edges after a press → outputs 0 immediately, no pulse. Button held through reset release → btn_rise 6 edges after release.
- Repeat (macro defined): hold btn_in[0] high → btn_repeat[0] pulses 8, 11 and 14 cycles after btn_rise[0]. Releasing stops the pulses. With the macro undefined, btn_repeat stays 0 throughout.
